// File: rtl/matrix_scan_driver_pkg.sv
// Shared Life-board geometry, default scan timing and scan state encoding.
// Also used by the Life engine and board copy stages.
package matrix_scan_driver_pkg;

    localparam int unsigned GRID_ROWS     = 16;
    localparam int unsigned GRID_COLS     = 16;
    localparam int unsigned BOARD_W       = GRID_ROWS * GRID_COLS;
    localparam int unsigned DWELL_DEFAULT = 3125;
    localparam int unsigned BLANK_DEFAULT = 32;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Bits needed to count 0..max(dwell,blank)-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
        int unsigned m;
        m = (dwell > blank) ? dwell : blank;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_timer.sv
// Row/phase counters and BLANK/DRIVE sequencing for the matrix scan.
// With MATRIX_SCAN_DIM_EN defined, also exports the 16-cycle PWM phase.
module matrix_scan_driver_scan_timer
    import matrix_scan_driver_pkg::*;
#(
    parameter int unsigned ROWS  = GRID_ROWS,
    parameter int unsigned DWELL = DWELL_DEFAULT,
    parameter int unsigned BLANK = BLANK_DEFAULT,
    localparam int unsigned CNT_W = cnt_width(DWELL, BLANK),
    localparam int unsigned ROW_W = idx_width(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output scan_state_e      state,
    output logic [ROW_W-1:0] row,
`ifdef MATRIX_SCAN_DIM_EN
    output logic [3:0]       phase_c,
`endif
    output logic             frame_first_c,
    output logic             boundary_c
);

    localparam int unsigned DWELL_LAST = (DWELL == 0) ? 0 : DWELL - 1;
    localparam int unsigned BLANK_LAST = (BLANK == 0) ? 0 : BLANK - 1;
    localparam int unsigned ROW_LAST   = ROWS - 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [ROW_W-1:0] row_d;
    scan_state_e      state_d;
    logic             blank_done_c;
    logic             dwell_done_c;
    logic             last_row_c;

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            row   <= row_d;
        end
    end

    // Next state: BLANK=0 collapses the gap so DRIVE follows DRIVE
    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        row_d   = row;
        unique case (state)
            ST_BLANK: begin
                if (blank_done_c) begin
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (dwell_done_c) begin
                    cnt_d   = '0;
                    row_d   = last_row_c ? '0 : row + ROW_W'(1);
                    state_d = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_BLANK;
            end
        endcase
    end

    // Terminal-count outputs
    always_comb begin
        blank_done_c  = (BLANK == 0) || (cnt == CNT_W'(BLANK_LAST));
        dwell_done_c  = (cnt == CNT_W'(DWELL_LAST));
        last_row_c    = (row == ROW_W'(ROW_LAST));
        frame_first_c = (state == ST_DRIVE) && (cnt == '0) && (row == '0);
        boundary_c    = (state == ST_DRIVE) && dwell_done_c && last_row_c;
`ifdef MATRIX_SCAN_DIM_EN
        phase_c       = 4'(cnt);
`endif
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// Double-buffered row-scan driver for the 16x16 Life LED matrix.
// Optional MATRIX_SCAN_DIM_EN adds a per-frame 4-bit brightness PWM on C.
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int unsigned ROWS  = GRID_ROWS,
    parameter int unsigned COLS  = GRID_COLS,
    parameter int unsigned DWELL = DWELL_DEFAULT,
    parameter int unsigned BLANK = BLANK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] board_in,
    input  logic                 board_valid,
`ifdef MATRIX_SCAN_DIM_EN
    input  logic [3:0]           bright,
`endif
    output logic [ROWS-1:0]      R,
    output logic [COLS-1:0]      C,
    output logic                 frame_start,
    output logic                 pending
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned ROW_W = idx_width(ROWS);

    scan_state_e      state;
    logic [ROW_W-1:0] row;
    logic             frame_first_c;
    logic             boundary_c;

    logic [CELLS-1:0] shadow;
    logic [CELLS-1:0] shadow_d;
    logic [CELLS-1:0] display;
    logic [CELLS-1:0] display_d;
    logic             pending_d;
    logic [COLS-1:0]  row_data [ROWS];
    logic [ROWS-1:0]  r_d;
    logic [COLS-1:0]  c_d;
    logic             frame_start_d;

`ifdef MATRIX_SCAN_DIM_EN
    logic [3:0]       phase_c;
    logic [3:0]       bright_q;
    logic [3:0]       bright_eff_c;
`endif

    matrix_scan_driver_scan_timer #(
        .ROWS  (ROWS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_scan_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .row           (row),
`ifdef MATRIX_SCAN_DIM_EN
        .phase_c       (phase_c),
`endif
        .frame_first_c (frame_first_c),
        .boundary_c    (boundary_c)
    );

    // Buffer update: a strobe on the boundary cycle bypasses the shadow
    always_comb begin
        shadow_d  = shadow;
        display_d = display;
        pending_d = pending;
        if (board_valid) begin
            shadow_d  = board_in;
            pending_d = 1'b1;
        end
        if (boundary_c) begin
            pending_d = 1'b0;
            if (board_valid) begin
                display_d = board_in;
            end else if (pending) begin
                display_d = shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            shadow  <= shadow_d;
            display <= display_d;
            pending <= pending_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ROWS; i++) begin
            row_data[i] = display[i*COLS +: COLS];
        end
    end

`ifdef MATRIX_SCAN_DIM_EN
    // Brightness is latched at the first DRIVE cycle of row 0 and used there too
    always_comb begin
        bright_eff_c = frame_first_c ? bright : bright_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 4'd0;
        end else if (frame_first_c) begin
            bright_q <= bright;
        end
    end
`endif

    // Output decode, registered below
    always_comb begin
        r_d           = '0;
        c_d           = '0;
        frame_start_d = frame_first_c;
        if (state == ST_DRIVE) begin
            r_d = ROWS'(1) << row;
            c_d = row_data[row];
`ifdef MATRIX_SCAN_DIM_EN
            if (phase_c >= bright_eff_c) begin
                c_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R           <= '0;
            C           <= '0;
            frame_start <= 1'b0;
        end else begin
            R           <= r_d;
            C           <= c_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed self-checking bench for matrix_scan_driver with DWELL=4, BLANK=2.
module tb_matrix_scan_driver;

    localparam int unsigned DWELL_T = 4;
    localparam int unsigned BLANK_T = 2;
    localparam int unsigned ROW_T   = DWELL_T + BLANK_T;
    localparam int unsigned FRAME_T = 16 * ROW_T;

    logic         clk;
    logic         rst_n;
    logic [255:0] board_in;
    logic         board_valid;
    logic [15:0]  R;
    logic [15:0]  C;
    logic         frame_start;
    logic         pending;
`ifdef MATRIX_SCAN_DIM_EN
    logic [3:0]   bright;
`endif

    int n_checks;
    int n_errors;

    matrix_scan_driver #(
        .ROWS  (16),
        .COLS  (16),
        .DWELL (DWELL_T),
        .BLANK (BLANK_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .board_in    (board_in),
        .board_valid (board_valid),
`ifdef MATRIX_SCAN_DIM_EN
        .bright      (bright),
`endif
        .R           (R),
        .C           (C),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [255:0] b);
        board_in    = b;
        board_valid = 1'b1;
        tick();
        board_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    function automatic logic [255:0] fill(input logic [15:0] even_row, input logic [15:0] odd_row);
        logic [255:0] b;
        for (int r = 0; r < 16; r++) begin
            b[r*16 +: 16] = (r % 2 == 0) ? even_row : odd_row;
        end
        return b;
    endfunction

    // Expected R/C for frame-relative cycle c when every row shows even/odd data
    task automatic check_scan(input string tag, input int c, input logic [15:0] even_row,
                              input logic [15:0] odd_row);
        int k;
        int p;
        logic [15:0] exp_r;
        logic [15:0] exp_c;
        k = c / ROW_T;
        p = c % ROW_T;
        exp_r = (p < DWELL_T) ? 16'(1 << k) : 16'h0000;
        exp_c = (p < DWELL_T) ? ((k % 2 == 0) ? even_row : odd_row) : 16'h0000;
        check({tag, "_R"}, 32'(R), 32'(exp_r));
        check({tag, "_C"}, 32'(C), 32'(exp_c));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        board_in    = '0;
        board_valid = 1'b0;
`ifdef MATRIX_SCAN_DIM_EN
        bright      = 4'hF;
`endif
        repeat (3) tick();
        check("rst_R", 32'(R), 32'h0);
        check("rst_C", 32'(C), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);

        // First DRIVE visible three cycles after release
        rst_n = 1'b1;
        tick();
        check("boot_c1_R", 32'(R), 32'h0);
        tick();
        check("boot_c2_R", 32'(R), 32'h0);
        tick();
        check("boot_c3_R", 32'(R), 32'h0001);
        check("boot_c3_C", 32'(C), 32'h0);
        check("boot_c3_fs", 32'(frame_start), 32'h1);

        // Load all-ones; shown only from the next frame
        strobe({256{1'b1}});
        check("ones_pending", 32'(pending), 32'h1);
        check("ones_deferred_C", 32'(C), 32'h0);
        wait_fs();
        check("ones_pending_clr", 32'(pending), 32'h0);
        for (int c = 0; c < int'(FRAME_T); c++) begin
            check_scan("scan", c, 16'hFFFF, 16'hFFFF);
            check("scan_fs", 32'(frame_start), (c == 0) ? 32'h1 : 32'h0);
            tick();
        end
        check("scan_next_fs", 32'(frame_start), 32'h1);
        check("scan_next_R", 32'(R), 32'h0001);

        // Deferred swap: checkerboard strobed during row 5
        repeat (31) tick();
        strobe(fill(16'hAAAA, 16'h5555));
        check("swap_pending", 32'(pending), 32'h1);
        for (int c = 32; c < int'(FRAME_T); c++) begin
            check_scan("swap_old", c, 16'hFFFF, 16'hFFFF);
            if (c == 90) check("swap_pending_hold", 32'(pending), 32'h1);
            tick();
        end
        check("swap_fs", 32'(frame_start), 32'h1);
        check("swap_row0_C", 32'(C), 32'hAAAA);
        check("swap_pending_clr", 32'(pending), 32'h0);
        repeat (ROW_T) tick();
        check("swap_row1_R", 32'(R), 32'h0002);
        check("swap_row1_C", 32'(C), 32'h5555);

        // Last strobe wins
        wait_fs();
        repeat (10) tick();
        strobe(fill(16'h1234, 16'h4321));
        repeat (29) tick();
        strobe(fill(16'hBEEF, 16'h0FF0));
        check("lw_pending", 32'(pending), 32'h1);
        wait_fs();
        for (int c = 0; c < int'(FRAME_T); c++) begin
            if (c % ROW_T == 0) check_scan("lw", c, 16'hBEEF, 16'h0FF0);
            tick();
        end

        // Strobe on the exact frame-boundary cycle goes straight to display
        wait_fs();
        repeat (92) tick();
        strobe(fill(16'h0F0F, 16'hF0F0));
        check("coll_pending", 32'(pending), 32'h0);
        repeat (3) tick();
        check("coll_fs", 32'(frame_start), 32'h1);
        check("coll_row0_C", 32'(C), 32'h0F0F);
        check("coll_pending_after", 32'(pending), 32'h0);

        // Reset mid-DRIVE with a generation pending
        tick();
        strobe(fill(16'hC3C3, 16'h3C3C));
        check("mid_pending", 32'(pending), 32'h1);
        check("mid_R", 32'(R), 32'h0001);
        check("mid_C", 32'(C), 32'h0F0F);
        rst_n = 1'b0;
        #1;
        check("mid_rst_R", 32'(R), 32'h0);
        check("mid_rst_C", 32'(C), 32'h0);
        check("mid_rst_pending", 32'(pending), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rerun_R", 32'(R), 32'h0001);
        check("rerun_C", 32'(C), 32'h0);
        check("rerun_fs", 32'(frame_start), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
